// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths,
// the NOP returned on faulting fetches and the FSM state encodings.
package imem_responder_pkg;

   // Default widths of the core's address and instruction buses.
   localparam int ADDR_BUS_W = 64;
   localparam int INST_BUS_W = 32;

   typedef logic [ADDR_BUS_W-1:0] addr_bus_t;
   typedef logic [INST_BUS_W-1:0] inst_bus_t;

   // Default byte address that maps onto word 0 of the store.
   localparam addr_bus_t BASE_ADDR_DEF = 64'h8000_0000;

   // addi x0, x0, 0 -- handed back instead of data when a fetch faults.
   localparam inst_bus_t INST_NOP = 32'h0000_0013;

   // Responder FSM encodings.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Wide enough for LATENCY-2 with LATENCY up to 15.
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/imem_store.sv
// DEPTH_WORDS x INST_W synchronous instruction RAM.
// One registered read port with enable, one write port. When both ports hit
// the same word on the same edge the read returns the word as it was before
// the write.
import imem_responder_pkg::*;

module imem_store #(
   parameter int DEPTH_WORDS = 1024,
   parameter int INST_W      = 32,
   parameter int IDX_W       = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rd_en_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [INST_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [INST_W-1:0] wr_data_i
);

   logic [INST_W-1:0] mem_q [DEPTH_WORDS];
   logic [INST_W-1:0] rd_data_q;

   // Write port; contents survive reset so a preloaded program stays put.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Registered read; non-blocking read of mem_q gives read-before-write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_idx_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder serving core fetches.
// Accepts a byte address on a valid/ready request channel, waits LATENCY
// cycles and returns instruction + error flag on a valid/ready response
// channel. Side load port preloads the store.
// Optional fetch/error statistics counters: define IMEM_STATS_EN.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high; the responder holds RespValid, RespInst and
// RespErr stable until that edge, and only samples ReqAddr on its accept edge.
import imem_responder_pkg::*;

module imem_responder #(
   parameter int                ADDR_W      = ADDR_BUS_W,
   parameter int                INST_W      = INST_BUS_W,
   parameter int                DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int                LATENCY     = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [ADDR_W-1:0] ReqAddr,
   output logic              RespValid,
   input  logic              RespReady,
   output logic [INST_W-1:0] RespInst,
   output logic              RespErr,
   input  logic              LoadEnable,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [INST_W-1:0] LoadData
`ifdef IMEM_STATS_EN
   ,
   output logic [31:0]       FetchCount,
   output logic [31:0]       ErrCount
`endif
);

   localparam int                IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // Size of the mapped window in bytes.
   localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH_WORDS) << 2;

   // Address mapping: unsigned offset from the base, so anything below the
   // base wraps to a huge offset and lands out of range.
   logic [ADDR_W-1:0] req_off, load_off;
   logic [IDX_W-1:0]  req_idx, load_idx;
   logic              req_err, load_err;

   assign req_off  = ReqAddr - BASE_ADDR;
   assign req_idx  = req_off[IDX_W+1:2];
   assign req_err  = (ReqAddr[1:0] != 2'b00) || (req_off >= SPAN);

   assign load_off = LoadAddr - BASE_ADDR;
   assign load_idx = load_off[IDX_W+1:2];
   assign load_err = (LoadAddr[1:0] != 2'b00) || (load_off >= SPAN);

   logic [1:0]            state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  err_q, err_d;
   logic                  accept;
   logic                  rd_en;
   logic [IDX_W-1:0]      rd_idx;
   logic [INST_W-1:0]     rd_data;

   assign accept = ReqValid && (state_q == ST_IDLE);

   // Next-state logic; the store is read on the edge that enters RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = err_q;
      rd_en   = 1'b0;
      rd_idx  = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               idx_d = req_idx;
               err_d = req_err;
               if (LATENCY == 1) begin
                  // Address is not latched yet, so read straight off the bus.
                  state_d = ST_RESP;
                  rd_en   = !req_err;
                  rd_idx  = req_idx;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_CNT_W'(LATENCY - 2);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               rd_en   = !err_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (RespReady) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and request registers; reset drops any pending fetch.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   imem_store #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INST_W      (INST_W),
      .IDX_W       (IDX_W)
   ) u_store (
      .clk_i     (Clk),
      .rst_i     (Rst),
      .rd_en_i   (rd_en),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data),
      .wr_en_i   (LoadEnable && !load_err),
      .wr_idx_i  (load_idx),
      .wr_data_i (LoadData)
   );

   assign ReqReady  = (state_q == ST_IDLE);
   assign RespValid = (state_q == ST_RESP);
   assign RespErr   = RespValid && err_q;
   assign RespInst  = !RespValid ? '0 : (err_q ? INST_W'(INST_NOP) : rd_data);

`ifdef IMEM_STATS_EN
   logic [31:0] fetch_cnt_q, err_cnt_q;

   // Accept statistics; both counters wrap naturally.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         fetch_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else if (accept) begin
         fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (req_err) begin
            err_cnt_q <= err_cnt_q + 32'd1;
         end
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign ErrCount   = err_cnt_q;
`else
   // Statistics disabled: no counters, no ports.
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with LATENCY=1 and one with
// LATENCY=3 on a shared clock and reset. Define IMEM_STATS_EN to also cover
// the statistics counters.
`timescale 1ns/1ps

module tb_imem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Per-instance signals: index 0 -> LATENCY=1, index 1 -> LATENCY=3.
  logic        req_valid [2];
  logic        req_ready [2];
  logic [63:0] req_addr  [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_inst [2];
  logic        resp_err  [2];
  logic        load_en   [2];
  logic [63:0] load_addr [2];
  logic [31:0] load_data [2];
`ifdef IMEM_STATS_EN
  logic [31:0] fetch_count[2];
  logic [31:0] err_count  [2];
`endif

  // Expected {err, inst} per instance, pushed at request, popped at response.
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  imem_responder #(.LATENCY(1)) u_l1 (
    .Clk(clk), .Rst(rst),
    .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqAddr(req_addr[0]),
    .RespValid(resp_valid[0]), .RespReady(resp_ready[0]),
    .RespInst(resp_inst[0]), .RespErr(resp_err[0]),
    .LoadEnable(load_en[0]), .LoadAddr(load_addr[0]), .LoadData(load_data[0])
`ifdef IMEM_STATS_EN
    , .FetchCount(fetch_count[0]), .ErrCount(err_count[0])
`endif
  );

  imem_responder #(.LATENCY(3)) u_l3 (
    .Clk(clk), .Rst(rst),
    .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqAddr(req_addr[1]),
    .RespValid(resp_valid[1]), .RespReady(resp_ready[1]),
    .RespInst(resp_inst[1]), .RespErr(resp_err[1]),
    .LoadEnable(load_en[1]), .LoadAddr(load_addr[1]), .LoadData(load_data[1])
`ifdef IMEM_STATS_EN
    , .FetchCount(fetch_count[1]), .ErrCount(err_count[1])
`endif
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input int s, input logic [63:0] addr, input logic [31:0] data);
    @(negedge clk);
    load_en[s]   = 1'b1;
    load_addr[s] = addr;
    load_data[s] = data;
    @(negedge clk);
    load_en[s]   = 1'b0;
  endtask

  task automatic pop_exp(input int s, output logic [32:0] e);
    if (s == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
  endtask

  // Waits for the response of an already-accepted request (called at the
  // first negedge after the accept edge), checks latency, content, stability
  // while RespReady stays low for `hold` cycles, then completes the handshake.
  task automatic finish_fetch(input int s, input int lat, input int hold, input string tag);
    logic [32:0] e;
    int cycles;
    cycles = 1;
    while (!resp_valid[s] && cycles < 20) begin
      check({tag, "_busy_ready"}, 64'(req_ready[s]), 64'(0));
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(lat));
    pop_exp(s, e);
    if (resp_valid[s]) begin
      check({tag, "_inst"}, 64'(resp_inst[s]), 64'(e[31:0]));
      check({tag, "_err"}, 64'(resp_err[s]), 64'(e[32]));
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 64'(resp_valid[s]), 64'(1));
        check({tag, "_hold_inst"}, 64'({resp_err[s], resp_inst[s]}), 64'(e));
        check({tag, "_hold_ready"}, 64'(req_ready[s]), 64'(0));
      end
      resp_ready[s] = 1'b1;
      @(negedge clk);
      resp_ready[s] = 1'b0;
      check({tag, "_post_ready"}, 64'(req_ready[s]), 64'(1));
      check({tag, "_post_valid"}, 64'(resp_valid[s]), 64'(0));
    end else begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
    end
  endtask

  task automatic fetch(input int s, input int lat, input logic [63:0] addr,
                       input logic [31:0] einst, input logic eerr,
                       input int hold, input string tag);
    @(negedge clk);
    if (s == 0) exp_q0.push_back({eerr, einst});
    else        exp_q1.push_back({eerr, einst});
    check({tag, "_accept_ready"}, 64'(req_ready[s]), 64'(1));
    req_valid[s] = 1'b1;
    req_addr[s]  = addr;
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_addr[s]  = 64'hDEAD_BEEF_0000_0000;
    finish_fetch(s, lat, hold, tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rdata;
    logic [63:0] raddr;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b0;
      load_en[i] = 1'b0; load_addr[i] = '0; load_data[i] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 64'(req_ready[i]), 64'(1));
      check("rst_resp_valid", 64'(resp_valid[i]), 64'(0));
      check("rst_resp_inst", 64'(resp_inst[i]), 64'(0));
      check("rst_resp_err", 64'(resp_err[i]), 64'(0));
    end
    rst = 1'b0;

    // Basic fetch, LATENCY=1.
    load_word(0, BASE, 32'h0010_0093);
    fetch(0, 1, BASE, 32'h0010_0093, 1'b0, 1, "l1_word0");

    // LATENCY=3 with a 5-cycle stall on the response side.
    load_word(1, BASE + 64'd4, 32'h0040_0113);
    fetch(1, 3, BASE + 64'd4, 32'h0040_0113, 1'b0, 5, "l3_stall");

    // Faulting fetches: misaligned, past the top, below the base.
    fetch(0, 1, BASE + 64'd2, NOP, 1'b1, 1, "err_misalign");
    fetch(0, 1, BASE + 64'h1000, NOP, 1'b1, 1, "err_top");
    fetch(0, 1, 64'h7FFF_FFFC, NOP, 1'b1, 1, "err_below");
    fetch(1, 3, BASE + 64'd1, NOP, 1'b1, 2, "l3_err_misalign");

    // Last valid word, and an ignored out-of-range load.
    load_word(0, BASE + 64'hFFC, 32'hCAFE_F00D);
    load_word(0, BASE + 64'h1000, 32'h5555_5555);
    load_word(0, BASE + 64'hFFE, 32'h6666_6666);
    fetch(0, 1, BASE + 64'hFFC, 32'hCAFE_F00D, 1'b0, 1, "top_word");

    // Same-edge load and read of word 2 returns the old contents.
    load_word(0, BASE + 64'd8, 32'h1111_1111);
    @(negedge clk);
    exp_q0.push_back({1'b0, 32'h1111_1111});
    req_valid[0] = 1'b1; req_addr[0] = BASE + 64'd8;
    load_en[0] = 1'b1; load_addr[0] = BASE + 64'd8; load_data[0] = 32'hAAAA_AAAA;
    @(negedge clk);
    req_valid[0] = 1'b0; load_en[0] = 1'b0;
    finish_fetch(0, 1, 1, "collide_old");
    fetch(0, 1, BASE + 64'd8, 32'hAAAA_AAAA, 1'b0, 1, "collide_new");

    // Random preload/fetch pairs.
    for (int i = 0; i < 6; i++) begin
      raddr = BASE + 64'(4 * $urandom_range(16, 1023));
      rdata = $urandom;
      load_word(0, raddr, rdata);
      fetch(0, 1, raddr, rdata, 1'b0, $urandom_range(1, 3), "rand");
    end

    // Reset in the middle of a LATENCY=3 wait.
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = BASE + 64'd4;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_valid", 64'(resp_valid[1]), 64'(0));
    check("rst_wait_ready", 64'(req_ready[1]), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wait_dropped", 64'(resp_valid[1]), 64'(0));
    end
    fetch(1, 3, BASE + 64'd4, 32'h0040_0113, 1'b0, 1, "rst_mem_kept");
    fetch(0, 1, BASE, 32'h0010_0093, 1'b0, 1, "rst_mem_kept_l1");

`ifdef IMEM_STATS_EN
    // Counters restart from the reset above; redo a clean reset first.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("stats_rst_fetch", 64'(fetch_count[0]), 64'(0));
    fetch(0, 1, BASE, 32'h0010_0093, 1'b0, 1, "st_g0");
    fetch(0, 1, BASE + 64'd8, 32'hAAAA_AAAA, 1'b0, 1, "st_g1");
    fetch(0, 1, BASE + 64'hFFC, 32'hCAFE_F00D, 1'b0, 1, "st_g2");
    fetch(0, 1, BASE + 64'd3, NOP, 1'b1, 1, "st_bad");
    check("stats_fetch", 64'(fetch_count[0]), 64'(4));
    check("stats_err", 64'(err_count[0]), 64'(1));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("stats_clr_fetch", 64'(fetch_count[0]), 64'(0));
    check("stats_clr_err", 64'(err_count[0]), 64'(0));
`endif

    // Scoreboard must be drained.
    check("exp_q0_empty", 64'(exp_q0.size()), 64'(0));
    check("exp_q1_empty", 64'(exp_q1.size()), 64'(0));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder that serves the core's fetch requests.
- Accepts a fetch address over a valid/ready request channel, waits a fixed number of wait-state cycles, then returns the 32-bit instruction and an error flag over a valid/ready response channel.
- Holds a synchronous word-addressed instruction store, preloadable through a side load port. Sits between the core's PC/fetch logic and the instruction store; it is the memory-side counterpart to the core's instruction input.

Parameters:
- ADDR_W, 64, fetch/load address width
- INST_W, 32, instruction width
- DEPTH_WORDS, 1024, number of instruction words stored
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- LATENCY, 1, cycles from request accept to RespValid; legal range 1..15

Ports:
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous active-high reset
- ReqValid  in  1  fetch request valid
- ReqReady  out  1  responder can accept a request
- ReqAddr  in  ADDR_W  fetch byte address
- RespValid  out  1  response valid
- RespReady  in  1  core accepts the response
- RespInst  out  INST_W  fetched instruction
- RespErr  out  1  misaligned or out-of-range fetch
- LoadEnable  in  1  preload write strobe
- LoadAddr  in  ADDR_W  preload byte address, same mapping as ReqAddr
- LoadData  in  INST_W  preload word

Behaviour:
- Reset (Rst=1 at a clock edge):
  - State goes to IDLE.
  - Outputs: ReqReady=1 (state IDLE), RespValid=0, RespInst=0, RespErr=0.
  - Wait counter cleared.
  - Memory contents are NOT cleared.
  - Reset mid-WAIT or mid-RESP drops the pending fetch silently.
- FSM states:
  - IDLE: ReqReady=1. ReqValid=1 latches ReqAddr and computes the error flag. Goes to RESP if LATENCY==1, else to WAIT with counter=LATENCY-2.
  - WAIT: ReqReady=0. Counter decrements each cycle. At counter==0, goes to RESP.
  - RESP: RespValid=1. RespInst and RespErr are stable until handshake. RespValid&&RespReady returns to IDLE.
- Timing:
  - RespValid rises exactly LATENCY cycles after the accept edge.
  - The memory read is registered on the transition into RESP.
  - Peak throughput: one fetch per LATENCY+1 cycles when RespReady is held high.
- Address mapping:
  - off = ReqAddr - BASE_ADDR, unsigned ADDR_W-bit subtraction; addresses below base wrap to large values.
  - Word index = off[ADDR_W-1:2].
  - Error if ReqAddr[1:0]!=0 or off >= DEPTH_WORDS*4.
  - On error: RespErr=1, RespInst=32'h0000_0013 (NOP), memory not read.
- Load port:
  - Same mapping as fetch. Accepted in any state.
  - Out-of-range or misaligned loads are ignored.
  - A load and a fetch read of the same word in the same cycle: the read returns the old word.
- ReqValid while not in IDLE is ignored (ReqReady=0). ReqAddr is sampled only at accept.
- RespReady outside RESP has no effect.

Optional Feature:
- Macro: IMEM_STATS_EN.
- When defined:
  - Adds output FetchCount (32 bits) and output ErrCount (32 bits).
  - Both reset to 0.
  - FetchCount increments on every request accept.
  - ErrCount increments on accepts whose error flag is set.
  - Both wrap from 32'hFFFF_FFFF to 0.
- When undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared defines file holds:
  - INST_NOP (32'h0000_0013)
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - width macros, reusing the existing AddrBus/InstBus definitions
- One sub-module: imem_store, a DEPTH_WORDS x INST_W synchronous RAM.
  - One registered read port with enable.
  - One write port.
  - Read-before-write on a same-address collision.

Test Plan:
- Preload word 0 = 32'h0010_0093 via the load port; LATENCY=1; fetch 64'h8000_0000 -> RespValid one cycle after accept, RespInst=32'h0010_0093, RespErr=0.
- LATENCY=3; fetch 64'h8000_0004 with RespReady held low 5 cycles -> RespValid at +3 cycles; RespInst and RespErr stable for all 5 cycles; ReqReady=0 throughout; ReqReady=1 the cycle after the handshake.
- Fetch 64'h8000_0002 -> RespErr=1, RespInst=32'h0000_0013. Fetch 64'h8000_1000 (DEPTH_WORDS=1024) -> RespErr=1. Fetch 64'h7FFF_FFFC -> RespErr=1.
- Load word 2 = 32'hAAAA_AAAA in the same cycle as the read of word 2 (old value 32'h1111_1111) -> response 32'h1111_1111; next fetch of word 2 -> 32'hAAAA_AAAA.
- Assert Rst during WAIT -> next cycle RespValid=0, ReqReady=1; the previously loaded memory word still reads back correctly.
- IMEM_STATS_EN: 3 good fetches + 1 misaligned fetch -> FetchCount=4, ErrCount=1; assert Rst -> both 0.
